// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Game sequencer for an 8x8 LED-matrix snake. It owns the snake body (a
// circular position buffer plus a 64-bit occupancy map), the move timing,
// direction arbitration, food placement and collision detection. It serves
// active-low row patterns to an external row-scan driver.
//
// Ports:
//   clk        in   1  system clock
//   clear      in   1  synchronous active-high reset (highest priority)
//   direction  in   4  button levels: [3]=down [0]=up [1]=left [2]=right
//   scan_row   in   3  row currently scanned by the display driver
//   row_g      out  8  body pattern for scan_row, active-low, bit n = col n
//   row_r      out  8  food pattern for scan_row, active-low
//   length     out  5  current snake length
//   running    out  1  high while the game is running
//   game_over  out  1  high once the game has ended
//
// Optional build macro:
//   SNAKE_WALL_KILL_EN  - leaving the matrix ends the game instead of wrapping.
//
// Positions are encoded {row[2:0], col[2:0]}, which is also the occupancy bit
// index.
// -----------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int TICK_DIV = 35000,
    parameter int LEN_MAX  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] direction,
    input  logic [2:0] scan_row,
    output logic [7:0] row_g,
    output logic [7:0] row_r,
    output logic [4:0] length,
    output logic       running,
    output logic       game_over
);

    localparam int PW = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Encoding chosen so that the opposite heading is the bitwise inverse.
    typedef enum logic [1:0] {
        HD_UP    = 2'd0,
        HD_LEFT  = 2'd1,
        HD_RIGHT = 2'd2,
        HD_DOWN  = 2'd3
    } head_t;

    // Occupancy map of the body right after reset: row 0, cols 0..INIT_LEN-1.
    function automatic logic [63:0] init_occ();
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < INIT_LEN; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    head_t           heading_r;
    head_t           heading_nxt_s;
    head_t           req_dir_s;
    logic            req_valid_s;
    logic [TW-1:0]   tick_r;
    logic [5:0]      pos_r [LEN_MAX];
    logic [PW-1:0]   head_ptr_r;
    logic [PW-1:0]   tail_ptr_r;
    logic [PW-1:0]   head_ptr_inc_s;
    logic [PW-1:0]   tail_ptr_inc_s;
    logic [63:0]     occ_r;
    logic [63:0]     occ_nxt_s;
    logic [4:0]      length_r;
    logic [5:0]      food_r;
    logic            food_pending_r;
    logic [5:0]      lfsr_r;
    logic [5:0]      head_pos_s;
    logic [5:0]      tail_pos_s;
    logic [5:0]      next_head_s;
    logic            tick_done_s;
    logic            move_s;
    logic            eat_s;
    logic            grow_s;
    logic            collide_s;
    logic            fail_s;
    logic            place_ok_s;

    assign head_pos_s     = pos_r[head_ptr_r];
    assign tail_pos_s     = pos_r[tail_ptr_r];
    assign tick_done_s    = (tick_r == TW'(TICK_DIV - 1));
    assign move_s         = (state_r == ST_RUN) && tick_done_s;
    assign head_ptr_inc_s = (head_ptr_r == PW'(LEN_MAX - 1)) ? {PW{1'b0}} : head_ptr_r + PW'(1);
    assign tail_ptr_inc_s = (tail_ptr_r == PW'(LEN_MAX - 1)) ? {PW{1'b0}} : tail_ptr_r + PW'(1);

    // Direction arbitration: fixed priority down > up > left > right, reversal ignored
    always_comb begin
        req_valid_s   = 1'b1;
        req_dir_s     = HD_UP;
        heading_nxt_s = heading_r;
        if (direction[3]) begin
            req_dir_s = HD_DOWN;
        end else if (direction[0]) begin
            req_dir_s = HD_UP;
        end else if (direction[1]) begin
            req_dir_s = HD_LEFT;
        end else if (direction[2]) begin
            req_dir_s = HD_RIGHT;
        end else begin
            req_valid_s = 1'b0;
        end
        if (req_valid_s && (req_dir_s != head_t'(~heading_r))) begin
            heading_nxt_s = req_dir_s;
        end else begin
            heading_nxt_s = heading_r;
        end
    end

    // Next head cell; 3-bit row/col arithmetic wraps modulo 8 by itself
    always_comb begin
        next_head_s = head_pos_s;
        case (heading_r)
            HD_UP:    next_head_s = {head_pos_s[5:3] - 3'd1, head_pos_s[2:0]};
            HD_DOWN:  next_head_s = {head_pos_s[5:3] + 3'd1, head_pos_s[2:0]};
            HD_LEFT:  next_head_s = {head_pos_s[5:3], head_pos_s[2:0] - 3'd1};
            HD_RIGHT: next_head_s = {head_pos_s[5:3], head_pos_s[2:0] + 3'd1};
            default:  next_head_s = head_pos_s;
        endcase
    end

    // Eating is suppressed while the previous food is still being relocated.
    assign eat_s     = move_s && !food_pending_r && (next_head_s == food_r);
    assign grow_s    = eat_s && (length_r < 5'(LEN_MAX));
    // Stepping onto the tail is legal when the tail is vacating the cell.
    assign collide_s = occ_r[next_head_s] && !((next_head_s == tail_pos_s) && !grow_s);

`ifdef SNAKE_WALL_KILL_EN
    logic wall_s;

    // Detect a move that would step off the edge of the matrix
    always_comb begin
        wall_s = 1'b0;
        case (heading_r)
            HD_UP:    wall_s = (head_pos_s[5:3] == 3'd0);
            HD_DOWN:  wall_s = (head_pos_s[5:3] == 3'd7);
            HD_LEFT:  wall_s = (head_pos_s[2:0] == 3'd0);
            HD_RIGHT: wall_s = (head_pos_s[2:0] == 3'd7);
            default:  wall_s = 1'b0;
        endcase
    end

    assign fail_s = collide_s | wall_s;
`else
    assign fail_s = collide_s;
`endif

    // The candidate must also avoid the cell the head enters on this very cycle.
    assign place_ok_s = food_pending_r && !occ_r[lfsr_r] && (lfsr_r != head_pos_s)
                        && !(move_s && (lfsr_r == next_head_s));

    // Occupancy after a successful move: drop the tail unless growing, then add the head
    always_comb begin
        occ_nxt_s = occ_r;
        if (!grow_s) begin
            occ_nxt_s[tail_pos_s] = 1'b0;
        end else begin
            occ_nxt_s = occ_r;
        end
        occ_nxt_s[next_head_s] = 1'b1;
    end

    // Game state next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (direction != 4'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (move_s && fail_s) begin
                    state_nxt_s = ST_OVER;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_OVER: state_nxt_s = ST_OVER;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Game state register
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Body, timing, heading, food and LFSR registers; all frozen once the game is over
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < LEN_MAX; i++) begin
                pos_r[i] <= (i < INIT_LEN) ? {3'd0, 3'(i)} : 6'd0;
            end
            head_ptr_r     <= PW'(INIT_LEN - 1);
            tail_ptr_r     <= {PW{1'b0}};
            occ_r          <= init_occ();
            length_r       <= 5'(INIT_LEN);
            heading_r      <= HD_RIGHT;
            tick_r         <= {TW{1'b0}};
            food_r         <= 6'b101_101;
            food_pending_r <= 1'b0;
            lfsr_r         <= 6'b000001;
        end else if (state_r != ST_OVER) begin
            lfsr_r    <= {lfsr_r[4:0], lfsr_r[5] ^ lfsr_r[4]};
            heading_r <= heading_nxt_s;
            if (state_r == ST_RUN) begin
                tick_r <= tick_done_s ? {TW{1'b0}} : tick_r + TW'(1);
            end else begin
                tick_r <= {TW{1'b0}};
            end
            if (place_ok_s) begin
                food_r         <= lfsr_r;
                food_pending_r <= 1'b0;
            end
            if (move_s && !fail_s) begin
                pos_r[head_ptr_inc_s] <= next_head_s;
                head_ptr_r            <= head_ptr_inc_s;
                occ_r                 <= occ_nxt_s;
                if (grow_s) begin
                    length_r <= length_r + 5'd1;
                end else begin
                    tail_ptr_r <= tail_ptr_inc_s;
                end
                if (eat_s) begin
                    food_pending_r <= 1'b1;
                end
            end
        end
    end

    // Food row pattern; blank while a new food cell is being searched for
    always_comb begin
        row_r = 8'hFF;
        if (!food_pending_r && (food_r[5:3] == scan_row)) begin
            row_r = ~(8'b0000_0001 << food_r[2:0]);
        end else begin
            row_r = 8'hFF;
        end
    end

    assign row_g     = ~occ_r[{scan_row, 3'b000} +: 8];
    assign length    = length_r;
    assign running   = (state_r == ST_RUN);
    assign game_over = (state_r == ST_OVER);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl. DUT A (INIT_LEN=3) is compared
// against a queue-based game model; DUT B (INIT_LEN=5) covers self-collision.
module tb_snake_game_ctrl;

    localparam int TICK   = 4;
    localparam int LMAX   = 16;
    localparam int INIT_A = 3;
    localparam int INIT_B = 5;
`ifdef SNAKE_WALL_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear_a = 1'b1, clear_b = 1'b1;
    logic [3:0] dir_a = 4'd0, dir_b = 4'd0;
    logic [2:0] row_a = 3'd0, row_b = 3'd0;
    logic [7:0] g_a, r_a, g_b, r_b;
    logic [4:0] len_a, len_b;
    logic       run_a, over_a, run_b, over_b;
    int         errors = 0;
    int         checks = 0;

    always #20 clk = ~clk;

    snake_game_ctrl #(.TICK_DIV(TICK), .LEN_MAX(LMAX), .INIT_LEN(INIT_A)) dut_a (
        .clk(clk), .clear(clear_a), .direction(dir_a), .scan_row(row_a),
        .row_g(g_a), .row_r(r_a), .length(len_a), .running(run_a), .game_over(over_a));

    snake_game_ctrl #(.TICK_DIV(TICK), .LEN_MAX(LMAX), .INIT_LEN(INIT_B)) dut_b (
        .clk(clk), .clear(clear_b), .direction(dir_b), .scan_row(row_b),
        .row_g(g_b), .row_r(r_b), .length(len_b), .running(run_b), .game_over(over_b));

    // ---------------- reference model of DUT A ----------------
    int         m_body[$];   // cell = row*8+col, head at back, tail at front
    int         m_state;     // 0 idle, 1 run, 2 over
    int         m_dr, m_dc;  // heading as a row/col step
    int         m_tick;
    int         m_food;
    bit         m_pend;
    logic [5:0] m_lfsr;

    function automatic bit m_occ(input int p);
        foreach (m_body[i]) if (m_body[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_row_g(input int r);
        logic [7:0] v = 8'hFF;
        foreach (m_body[i]) if (m_body[i] / 8 == r) v[m_body[i] % 8] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] m_row_r(input int r);
        logic [7:0] v = 8'hFF;
        if (!m_pend && (m_food / 8 == r)) v[m_food % 8] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_body.delete();
        for (int i = 0; i < INIT_A; i++) m_body.push_back(i);
        m_state = 0; m_dr = 0; m_dc = 1; m_tick = 0;
        m_food = 45; m_pend = 1'b0; m_lfsr = 6'b000001;
    endtask

    task automatic model_step(input logic [3:0] d, input logic c);
        int hr, hc, nr, nc, nh, rr, rc, food0, cand;
        bit req, pend0, move, eat, grow, coll, wall;
        if (c) begin model_reset(); return; end
        if (m_state == 2) return;
        hr = m_body[$] / 8; hc = m_body[$] % 8;
        pend0 = m_pend; food0 = m_food;
        move = (m_state == 1) && (m_tick == TICK - 1);
        nr = hr + m_dr; nc = hc + m_dc;
        wall = (nr < 0) || (nr > 7) || (nc < 0) || (nc > 7);
        nh = ((nr + 8) % 8) * 8 + ((nc + 8) % 8);
        coll = 1'b0;
        if (pend0) begin
            cand = int'(m_lfsr);
            if (!m_occ(cand) && !(move && cand == nh)) begin m_food = cand; m_pend = 1'b0; end
        end
        if (move) begin
            eat  = !pend0 && (nh == food0);
            grow = eat && (m_body.size() < LMAX);
            coll = m_occ(nh) && !(nh == m_body[0] && !grow);
            if (wall && KILL) coll = 1'b1;
            if (!coll) begin
                m_body.push_back(nh);
                if (!grow) void'(m_body.pop_front());
                if (eat) m_pend = 1'b1;
            end
        end
        req = 1'b1; rr = 0; rc = 0;
        if (d[3]) rr = 1; else if (d[0]) rr = -1; else if (d[1]) rc = -1; else if (d[2]) rc = 1; else req = 1'b0;
        if (req && !(rr == -m_dr && rc == -m_dc)) begin m_dr = rr; m_dc = rc; end
        if (m_state == 0) begin
            m_tick = 0;
            if (d != 4'd0) m_state = 1;
        end else begin
            m_tick = (m_tick + 1) % TICK;
            if (coll) m_state = 2;
        end
        m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step_a(input logic [3:0] d, input logic c);
        dir_a = d; clear_a = c;
        @(posedge clk);
        model_step(d, c);
        #2;
    endtask

    task automatic step_b(input logic [3:0] d, input logic c);
        dir_b = d; clear_b = c;
        @(posedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step_a(4'd0, 1'b1);
        repeat (20) step_a(4'd0, 1'b0);
        row_a = 3'd0; #1;
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", run_a); end
        checks++; if (over_a !== 1'b0) begin errors++; $display("FAIL reset_game_over got=%b exp=0", over_a); end
        checks++; if (len_a !== 5'd3) begin errors++; $display("FAIL reset_length got=%0d exp=3", len_a); end
        checks++; if (g_a !== 8'b11111000) begin errors++; $display("FAIL reset_row_g0 got=%b exp=11111000", g_a); end
        checks++; if (r_a !== 8'hFF) begin errors++; $display("FAIL reset_row_r0 got=%b exp=11111111", r_a); end
        row_a = 3'd5; #1;
        checks++; if (r_a !== 8'b11011111) begin errors++; $display("FAIL reset_row_r5 got=%b exp=11011111", r_a); end
    endtask

    task automatic test_start_move();
        step_a(4'b0100, 1'b0);
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL start_running got=%b exp=1", run_a); end
        repeat (4) step_a(4'd0, 1'b0);
        row_a = 3'd0; #1;
        checks++; if (g_a !== 8'b11110001) begin errors++; $display("FAIL first_move_row_g0 got=%b exp=11110001", g_a); end
    endtask

    task automatic test_reversal();
        repeat (8) step_a(4'b0010, 1'b0);
        row_a = 3'd0; #1;
        checks++; if (g_a !== 8'b11000111) begin errors++; $display("FAIL reversal_ignored got=%b exp=11000111", g_a); end
        step_a(4'b1001, 1'b0);
        repeat (3) step_a(4'd0, 1'b0);
        row_a = 3'd0; #1;
        checks++; if (g_a !== 8'b11001111) begin errors++; $display("FAIL priority_row_g0 got=%b exp=11001111", g_a); end
        row_a = 3'd1; #1;
        checks++; if (g_a !== 8'b11011111) begin errors++; $display("FAIL priority_down_row_g1 got=%b exp=11011111", g_a); end
    endtask

    task automatic test_eat();
        int  zeros, ov;
        bit  found;
        repeat (12) step_a(4'd0, 1'b0);
        checks++; if (len_a !== 5'd3) begin errors++; $display("FAIL pre_eat_length got=%0d exp=3", len_a); end
        repeat (4) step_a(4'd0, 1'b0);
        checks++; if (len_a !== 5'd4) begin errors++; $display("FAIL eat_length got=%0d exp=4", len_a); end
        row_a = 3'd2; #1;
        checks++; if (g_a !== 8'b11011111) begin errors++; $display("FAIL eat_tail_kept got=%b exp=11011111", g_a); end
        row_a = 3'd5; #1;
        checks++; if (g_a !== 8'b11011111) begin errors++; $display("FAIL eat_head_row5 got=%b exp=11011111", g_a); end
        checks++; if (r_a !== 8'hFF) begin errors++; $display("FAIL eat_food_blank got=%b exp=11111111", r_a); end
        found = 1'b0; zeros = 0; ov = 0;
        for (int cyc = 0; cyc < 64 && !found; cyc++) begin
            step_a(4'd0, 1'b0);
            zeros = 0; ov = 0;
            for (int r = 0; r < 8; r++) begin
                row_a = 3'(r); #1;
                for (int b = 0; b < 8; b++) begin
                    if (!r_a[b]) begin zeros++; if (!g_a[b]) ov++; end
                end
            end
            if (zeros != 0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL food_relocate_timeout got=none exp=food within 64 cycles"); end
        checks++; if (zeros != 1) begin errors++; $display("FAIL food_single_bit got=%0d exp=1", zeros); end
        checks++; if (ov != 0) begin errors++; $display("FAIL food_on_body got=%0d exp=0", ov); end
        row_a = 3'(m_food / 8); #1;
        checks++; if (r_a !== m_row_r(m_food / 8)) begin errors++; $display("FAIL food_cell got=%b exp=%b", r_a, m_row_r(m_food / 8)); end
    endtask

    task automatic test_wrap();
        step_a(4'd0, 1'b1);
        step_a(4'b0100, 1'b0);
        repeat (20) step_a(4'd0, 1'b0);
        row_a = 3'd0; #1;
        checks++; if (g_a !== 8'b00011111) begin errors++; $display("FAIL edge_row_g0 got=%b exp=00011111", g_a); end
        repeat (4) step_a(4'd0, 1'b0);
        if (KILL) begin
            checks++; if (over_a !== 1'b1 || run_a !== 1'b0) begin errors++; $display("FAIL wall_kill_state got=%b%b exp=10", over_a, run_a); end
            repeat (8) step_a(4'b1000, 1'b0);
            row_a = 3'd0; #1;
            checks++; if (g_a !== 8'b00011111) begin errors++; $display("FAIL wall_kill_frozen got=%b exp=00011111", g_a); end
        end else begin
            checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL wrap_running got=%b exp=1", run_a); end
            checks++; if (g_a !== 8'b00111110) begin errors++; $display("FAIL wrap_row_g0 got=%b exp=00111110", g_a); end
        end
    endtask

    task automatic test_clear_mid_game();
        step_a(4'd0, 1'b1);
        row_a = 3'd0; #1;
        checks++; if (g_a !== 8'b11111000) begin errors++; $display("FAIL clear_row_g0 got=%b exp=11111000", g_a); end
        checks++; if (len_a !== 5'd3 || run_a !== 1'b0 || over_a !== 1'b0) begin
            errors++; $display("FAIL clear_status got=len%0d run%b over%b exp=len3 run0 over0", len_a, run_a, over_a); end
        row_a = 3'd5; #1;
        checks++; if (r_a !== 8'b11011111) begin errors++; $display("FAIL clear_row_r5 got=%b exp=11011111", r_a); end
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic       c;
        int         r;
        step_a(4'd0, 1'b1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            c = ($urandom_range(0, 499) == 0) || (m_state == 2 && $urandom_range(0, 19) == 0);
            step_a(d, c);
            r = $urandom_range(0, 7);
            row_a = 3'(r); #1;
            checks++; if (g_a !== m_row_g(r)) begin errors++; $display("FAIL rand_row_g cyc=%0d row=%0d got=%b exp=%b", cyc, r, g_a, m_row_g(r)); end
            checks++; if (r_a !== m_row_r(r)) begin errors++; $display("FAIL rand_row_r cyc=%0d row=%0d got=%b exp=%b", cyc, r, r_a, m_row_r(r)); end
            checks++; if (len_a !== 5'(m_body.size())) begin errors++; $display("FAIL rand_length cyc=%0d got=%0d exp=%0d", cyc, len_a, m_body.size()); end
            checks++; if (run_a !== (m_state == 1) || over_a !== (m_state == 2)) begin
                errors++; $display("FAIL rand_state cyc=%0d got=run%b over%b exp_state=%0d", cyc, run_a, over_a, m_state); end
        end
    endtask

    task automatic test_self_collision();
        step_b(4'd0, 1'b1);
        row_b = 3'd0; #1;
        checks++; if (g_b !== 8'b11100000 || len_b !== 5'd5) begin errors++; $display("FAIL b_reset got=%b len%0d exp=11100000 len5", g_b, len_b); end
        step_b(4'b1000, 1'b0);
        repeat (4) step_b(4'd0, 1'b0);
        row_b = 3'd1; #1;
        checks++; if (g_b !== 8'b11101111 || over_b !== 1'b0) begin errors++; $display("FAIL b_move1 got=%b over%b exp=11101111 over0", g_b, over_b); end
        step_b(4'b0010, 1'b0);
        repeat (3) step_b(4'd0, 1'b0);
        row_b = 3'd0; #1;
        checks++; if (g_b !== 8'b11100011) begin errors++; $display("FAIL b_move2_row0 got=%b exp=11100011", g_b); end
        row_b = 3'd1; #1;
        checks++; if (g_b !== 8'b11100111 || over_b !== 1'b0) begin errors++; $display("FAIL b_move2_row1 got=%b over%b exp=11100111 over0", g_b, over_b); end
        step_b(4'b0001, 1'b0);
        repeat (3) step_b(4'd0, 1'b0);
        checks++; if (over_b !== 1'b1 || run_b !== 1'b0) begin errors++; $display("FAIL b_collide got=over%b run%b exp=over1 run0", over_b, run_b); end
        row_b = 3'd0; #1;
        checks++; if (g_b !== 8'b11100011 || len_b !== 5'd5) begin errors++; $display("FAIL b_frozen got=%b len%0d exp=11100011 len5", g_b, len_b); end
        step_b(4'd0, 1'b1);
        row_b = 3'd0; #1;
        checks++; if (g_b !== 8'b11100000 || over_b !== 1'b0 || run_b !== 1'b0) begin
            errors++; $display("FAIL b_clear got=%b over%b run%b exp=11100000 over0 run0", g_b, over_b, run_b); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_move();
        test_reversal();
        test_eat();
        test_wrap();
        test_clear_mid_game();
        test_random();
        test_self_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
